// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU's single memory port between instruction fetch and load/store.
// One transaction outstanding; data wins unless fetch has been starved DATA_BURST_MAX times.
module mem_port_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  input  logic        if_flush_in,
  output logic        if_gnt_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [3:0]  d_be_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_gnt_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        flush_pending_q, flush_pending_d;
  logic        if_gnt_q, if_gnt_d;
  logic        d_gnt_q, d_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic pick_data;
  logic fetch_dropped;

  // Fetch only beats a concurrent data request once the data streak hits the bound.
  assign pick_data     = d_req_in && !(if_req_in && (burst_cnt_q == BURST_MAX));
  assign fetch_dropped = flush_pending_q || if_flush_in;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    burst_cnt_d     = burst_cnt_q;
    flush_pending_d = flush_pending_q;
    if_gnt_d        = 1'b0;
    d_gnt_d         = 1'b0;
    if_rvalid_d     = 1'b0;
    d_rvalid_d      = 1'b0;
    if_rdata_d      = if_rdata_q;
    d_rdata_d       = d_rdata_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_be_d        = mem_be_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_req_in || d_req_in) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
          if (pick_data) begin
            owner_d     = OWN_DATA;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we_in;
            mem_be_d    = d_be_in;
            mem_addr_d  = d_addr_in;
            mem_wdata_d = d_wdata_in;
            if (if_req_in) begin
              burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
            end else begin
              burst_cnt_d = 4'd0;
            end
          end else begin
            owner_d     = OWN_FETCH;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = if_addr_in;
            mem_wdata_d = 32'd0;
            burst_cnt_d = 4'd0;
          end
        end
      end
      S_REQ: begin
        if (owner_q == OWN_FETCH && if_flush_in) begin
          flush_pending_d = 1'b1;
        end
        if (mem_ready_in) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q == OWN_FETCH && if_flush_in) begin
          flush_pending_d = 1'b1;
        end
        if (mem_rvalid_in) begin
          state_d         = S_IDLE;
          flush_pending_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? 32'd0 : mem_rdata_in;
          end else if (!fetch_dropped) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_in;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_FETCH;
      burst_cnt_q     <= 4'd0;
      flush_pending_q <= 1'b0;
      if_gnt_q        <= 1'b0;
      d_gnt_q         <= 1'b0;
      if_rvalid_q     <= 1'b0;
      d_rvalid_q      <= 1'b0;
      if_rdata_q      <= 32'd0;
      d_rdata_q       <= 32'd0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'd0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      burst_cnt_q     <= burst_cnt_d;
      flush_pending_q <= flush_pending_d;
      if_gnt_q        <= if_gnt_d;
      d_gnt_q         <= d_gnt_d;
      if_rvalid_q     <= if_rvalid_d;
      d_rvalid_q      <= d_rvalid_d;
      if_rdata_q      <= if_rdata_d;
      d_rdata_q       <= d_rdata_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign if_gnt_out    = if_gnt_q;
  assign d_gnt_out     = d_gnt_q;
  assign if_rvalid_out = if_rvalid_q;
  assign d_rvalid_out  = d_rvalid_q;
  assign if_rdata_out  = if_rdata_q;
  assign d_rdata_out   = d_rdata_q;
  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_be_out    = mem_be_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked against
// a transaction-level model of the arbitration, starvation bound, flush and response routing.
module tb_mem_port_arbiter;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = 32'd0;
  logic        if_flush_in = 1'b0;
  logic        if_gnt_out, if_rvalid_out;
  logic [31:0] if_rdata_out;
  logic        d_req_in = 1'b0;
  logic        d_we_in = 1'b0;
  logic [3:0]  d_be_in = 4'd0;
  logic [31:0] d_addr_in = 32'd0;
  logic [31:0] d_wdata_in = 32'd0;
  logic        d_gnt_out, d_rvalid_out;
  logic [31:0] d_rdata_out;
  logic        mem_req_out, mem_we_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic        mem_ready_in = 1'b0;
  logic        mem_rvalid_in = 1'b0;
  logic [31:0] mem_rdata_in = 32'd0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          streak = 0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata = 32'd0;
  bit          sticky = 1'b0;
  logic        obs_d_gnt = 1'b0;

  mem_port_arbiter #(.DATA_BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
    .if_gnt_out(if_gnt_out), .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
    .d_req_in(d_req_in), .d_we_in(d_we_in), .d_be_in(d_be_in), .d_addr_in(d_addr_in),
    .d_wdata_in(d_wdata_in), .d_gnt_out(d_gnt_out), .d_rvalid_out(d_rvalid_out),
    .d_rdata_out(d_rdata_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_be_out(mem_be_out), .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_ready_in(mem_ready_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_if_fields();
    if_addr_in = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic rand_d_fields();
    d_we_in    = 1'($urandom_range(0, 1));
    d_be_in    = 4'($urandom_range(1, 15));
    d_addr_in  = $urandom();
    d_wdata_in = $urandom();
  endtask

  task automatic check_quiet(input string tag);
    check1({tag, "_if_gnt"}, if_gnt_out, 1'b0);
    check1({tag, "_d_gnt"}, d_gnt_out, 1'b0);
    check1({tag, "_if_rvalid"}, if_rvalid_out, 1'b0);
    check1({tag, "_d_rvalid"}, d_rvalid_out, 1'b0);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd, input logic is_data);
    check({tag, "_addr"}, mem_addr_out, a);
    check1({tag, "_we"}, mem_we_out, we);
    check({tag, "_be"}, 32'(mem_be_out), 32'(be));
    if (is_data) check({tag, "_wdata"}, mem_wdata_out, wd);
  endtask

  task automatic check_zero(input string tag);
    check_quiet(tag);
    check({tag, "_if_rdata"}, if_rdata_out, 32'd0);
    check({tag, "_d_rdata"}, d_rdata_out, 32'd0);
    check1({tag, "_mem_req"}, mem_req_out, 1'b0);
    check_mem(tag, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
  endtask

  // Entered during an IDLE cycle with at least one request raised; returns in the
  // cycle the response pulse is visible (the next IDLE cycle).
  task automatic do_txn(input int w, input int rw, input bit flush, input logic [31:0] rdata);
    logic        pick_d;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we;
    pick_d = d_req_in && !(if_req_in && streak >= BMAX);
    if (pick_d) begin
      e_addr = d_addr_in; e_we = d_we_in; e_be = d_be_in; e_wdata = d_wdata_in;
    end else begin
      e_addr = if_addr_in; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'd0;
    end
    if (pick_d && if_req_in) streak = (streak < BMAX) ? streak + 1 : BMAX;
    else streak = 0;

    tick();
    if_flush_in = 1'b0;
    obs_d_gnt = d_gnt_out;
    check1("gnt_if", if_gnt_out, !pick_d);
    check1("gnt_d", d_gnt_out, pick_d);
    check1("gnt_mem_req", mem_req_out, 1'b1);
    check_mem("gnt_mem", e_addr, e_we, e_be, e_wdata, pick_d);
    if (!sticky) begin
      if (pick_d) begin d_req_in = 1'b0; rand_d_fields(); end
      else begin if_req_in = 1'b0; rand_if_fields(); end
    end
    mem_ready_in = (w == 0);
    for (int i = 1; i <= w; i++) begin
      mem_rvalid_in = 1'($urandom_range(0, 1));
      tick();
      check_quiet("wait");
      check1("wait_mem_req", mem_req_out, 1'b1);
      check_mem("wait_mem", e_addr, e_we, e_be, e_wdata, pick_d);
      if (i == w) begin mem_ready_in = 1'b1; mem_rvalid_in = 1'b0; end
    end

    tick();
    mem_ready_in = 1'b0;
    check_quiet("resp");
    check1("resp_mem_req", mem_req_out, 1'b0);
    check_mem("resp_mem", e_addr, e_we, e_be, e_wdata, pick_d);
    mem_rdata_in  = rdata;
    if_flush_in   = flush;
    mem_rvalid_in = (rw == 0);
    for (int i = 1; i <= rw; i++) begin
      tick();
      if_flush_in = 1'b0;
      check_quiet("resp_wait");
      if (i == rw) mem_rvalid_in = 1'b1;
    end

    tick();
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = $urandom();
    if (pick_d) exp_d_rdata = e_we ? 32'd0 : rdata;
    else if (!flush) exp_if_rdata = rdata;
    check1("done_d_rvalid", d_rvalid_out, pick_d);
    check1("done_if_rvalid", if_rvalid_out, !pick_d && !flush);
    check("done_d_rdata", d_rdata_out, exp_d_rdata);
    check("done_if_rdata", if_rdata_out, exp_if_rdata);
    check1("done_mem_req", mem_req_out, 1'b0);
  endtask

  initial begin
    logic [9:0] order;
    int w, rw;
    bit fl;

    // reset
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;

    // single fetch, zero-wait memory
    if_addr_in = 32'h0000_0000;
    if_req_in  = 1'b1;
    do_txn(0, 0, 1'b0, 32'h0050_0093);
    check("single_fetch_rdata", if_rdata_out, 32'h0050_0093);

    // simultaneous fetch and data write: data first, fetch at next IDLE
    if_addr_in = 32'h0000_0040; if_req_in = 1'b1;
    d_addr_in = 32'h0000_0100; d_we_in = 1'b1; d_be_in = 4'h3; d_wdata_in = 32'hDEAD_BEEF;
    d_req_in = 1'b1;
    do_txn(0, 0, 1'b0, 32'h1234_5678);
    check1("both_first_is_data", obs_d_gnt, 1'b1);
    check("both_write_rdata", d_rdata_out, 32'd0);
    do_txn(0, 0, 1'b0, 32'h0000_0013);
    check1("both_second_is_fetch", obs_d_gnt, 1'b0);

    // starvation bound with both requests held high
    sticky = 1'b1;
    rand_d_fields();
    d_req_in = 1'b1; if_req_in = 1'b1;
    order = '0;
    for (int i = 0; i < 10; i++) begin
      do_txn(0, 0, 1'b0, $urandom());
      order[i] = obs_d_gnt;
    end
    check("burst_order", 32'(order), 32'(10'b01111_01111));
    sticky = 1'b0;
    d_req_in = 1'b0; if_req_in = 1'b0;
    tick();

    // wait states on a data read
    rand_d_fields();
    d_we_in = 1'b0; d_req_in = 1'b1;
    do_txn(3, 2, 1'b0, 32'hCAFE_F00D);
    check("wait_read_rdata", d_rdata_out, 32'hCAFE_F00D);

    // flush during RESP, then a normal fetch
    rand_if_fields(); if_req_in = 1'b1;
    do_txn(0, 2, 1'b1, 32'hFFD0_0113);
    check1("flush_no_rvalid", if_rvalid_out, 1'b0);
    rand_if_fields(); if_req_in = 1'b1;
    do_txn(1, 1, 1'b0, 32'h0000_0297);
    check("after_flush_rdata", if_rdata_out, 32'h0000_0297);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      if (!if_req_in && $urandom_range(0, 1) == 1) if_req_in = 1'b1;
      if (!d_req_in && $urandom_range(0, 1) == 1) d_req_in = 1'b1;
      if_flush_in = ($urandom_range(0, 3) == 0);
      if (!if_req_in && !d_req_in) begin
        tick();
        if_flush_in = 1'b0;
        check_quiet("idle");
        continue;
      end
      w  = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      fl = (rw > 0) && ($urandom_range(0, 2) == 0);
      do_txn(w, rw, fl, $urandom());
    end

    // reset in the middle of RESP, then a stray response
    if_req_in = 1'b0; d_req_in = 1'b0; if_flush_in = 1'b0;
    tick();
    if_addr_in = 32'h0000_0200; if_req_in = 1'b1;
    tick();
    check1("rst_txn_gnt", if_gnt_out, 1'b1);
    if_req_in = 1'b0; mem_ready_in = 1'b1;
    tick();
    mem_ready_in = 1'b0; rst = 1'b0;
    tick();
    check_zero("mid_reset");
    rst = 1'b1; mem_rvalid_in = 1'b1; mem_rdata_in = 32'hA5A5_5A5A;
    tick();
    mem_rvalid_in = 1'b0;
    check_quiet("stray1");
    tick();
    check_quiet("stray2");
    check("stray_if_rdata", if_rdata_out, 32'd0);
    check("stray_d_rdata", d_rdata_out, 32'd0);
    check1("stray_mem_req", mem_req_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
